rr_mux_reg: RTL

Parametrised, registered N-channel multiplexer with round-robin arbitration and valid/ready handshakes on every channel and on the output. It generalises the fixed 4-to-1 32-bit select mux: the select comes from an internal fair arbiter rather than an input. The output is registered, and back-pressure from the consumer is honoured. It sits between multiple producers (e.g. memory, register file, ALU result paths) and a single shared consumer bus in the datapath.

---
 rtl/rr_mux_reg.sv | 108 ++++++++++
 1 files changed

// File: rtl/rr_mux_reg.sv
// Registered N-channel round-robin multiplexer with valid/ready on every input and the output.
// Optional build macro RR_MUX_FORCE_EN adds force_en/force_sel to pin the grant to one channel.
module rr_mux_reg #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NCH   = 4,
    parameter int unsigned SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
`ifdef RR_MUX_FORCE_EN
    ,
    input  logic                 force_en,
    input  logic [SELW-1:0]      force_sel
`endif
);

    logic [SELW-1:0]  last_q;
    logic [SELW:0]    cand;
    logic             rr_found;
    logic [SELW-1:0]  rr_idx;
    logic             gnt_found;
    logic [SELW-1:0]  gnt_idx;
    logic             forced;
    logic             load;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;

    // Rotating search from last_q+1; one extra bit so the wrap works for any NCH.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            cand = {1'b0, last_q} + (SELW+1)'(k);
            if (cand >= (SELW+1)'(NCH)) begin
                cand = cand - (SELW+1)'(NCH);
            end
            if (!rr_found && in_valid[cand[SELW-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = cand[SELW-1:0];
            end
        end
    end

    always_comb begin
`ifdef RR_MUX_FORCE_EN
        if (force_en) begin
            gnt_found = ({1'b0, force_sel} < (SELW+1)'(NCH)) && in_valid[force_sel];
            gnt_idx   = force_sel;
            forced    = 1'b1;
        end else begin
            gnt_found = rr_found;
            gnt_idx   = rr_idx;
            forced    = 1'b0;
        end
`else
        gnt_found = rr_found;
        gnt_idx   = rr_idx;
        forced    = 1'b0;
`endif
    end

    // Single-entry output slot: refillable whenever it is empty or draining this cycle.
    assign load = ~out_valid | out_ready;
    assign xfer = load & gnt_found & rst_n;

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (gnt_idx == SELW'(i)) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            last_q    <= SELW'(NCH - 1);
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_sel   <= gnt_idx;
            if (!forced) begin
                last_q <= gnt_idx;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
